cordic_nco_frontend: RTL and testbench
======================================

Name: cordic_nco_frontend

Overview:
- Phase-accumulator NCO and sample sequencer that sits directly upstream of the pipelined CORDIC rotator.
- Generates angle, Xin and Yin each cycle for sine/cosine generation, with Xin gain-precompensated.
- Tracks CORDIC pipeline latency with a valid delay line so downstream logic knows when Xout/Yout are meaningful.
- Supports continuous or fixed-count bursts, configured over a valid/ready port.

Parameters:
- DATA_WIDTH, 16, width of Xin/Yin; must match CORDIC.
- ANGLE_WIDTH, 32, phase width; 2π == 2^ANGLE_WIDTH.
- ITER, 16, CORDIC iteration count; CORDIC latency is ITER cycles.
- CNT_WIDTH, 16, burst-count width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  high only in IDLE.
- cfg_ftw  in  ANGLE_WIDTH  frequency tuning word (unsigned phase step).
- cfg_phase  in  ANGLE_WIDTH  start phase.
- cfg_amp  in  DATA_WIDTH-1  unsigned amplitude.
- cfg_count  in  CNT_WIDTH  samples per burst; 0 = continuous.
- start  in  1  start pulse (IDLE only).
- stop  in  1  stop request (RUN only).
- busy  out  1  state != IDLE.
- angle  out  ANGLE_WIDTH signed  to CORDIC angle.
- xin  out  DATA_WIDTH signed  to CORDIC Xin.
- yin  out  DATA_WIDTH signed  to CORDIC Yin; always 0.
- in_valid  out  1  angle/xin/yin carry a real sample.
- out_valid  out  1  CORDIC Xout/Yout valid this cycle.
- done  out  1  one-cycle pulse when the final burst sample leaves the CORDIC.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - All config registers, the accumulator, angle, xin, yin, in_valid, out_valid, done and the delay line clear to 0.
  - Reset mid-burst discards in-flight samples; no out_valid is raised for them.
- All outputs are registered.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_ready=1. A cycle with cfg_valid high captures ftw/phase/amp/count.
  - start with cfg_valid low: the accumulator loads cfg_phase and the state goes to RUN.
  - start and cfg_valid in the same cycle: the config is captured and start is ignored.
  - stop is ignored.
- RUN:
  - start is edge t → first sample at t+1: angle=phase, in_valid=1.
  - Sample k appears at t+1+k with angle = (phase + k·ftw) mod 2^ANGLE_WIDTH, reinterpreted as signed. Wrap is natural two's-complement overflow.
  - xin = (amp · K_INV_Q15) >>> 15, with K_INV_Q15 = 19899 (≈0.607253·2^15). Computed once at config capture and held.
  - yin = 0.
  - Burst mode (count=N>0): exactly N samples issued, then the state goes to DRAIN.
  - stop sampled high in cycle c: the sample shown in c is the last one; go to DRAIN at c+1. Applies in continuous mode too.
  - stop and terminal count in the same cycle: same result, a single transition.
  - start and cfg_valid are ignored.
- DRAIN:
  - in_valid=0; angle holds its last value.
  - Stay until the delay line is empty. done pulses in the same cycle as the last out_valid, and the state goes to IDLE on the next edge.
  - start, stop and cfg are all ignored.
- out_valid equals in_valid delayed by exactly ITER cycles. This matches the CORDIC's stage-0 register plus ITER-1 iteration registers.
- angle = -2^(ANGLE_WIDTH-1) (−π) is legal; the CORDIC handles it via its < −π/2 branch.
- Zero-amplitude or zero-ftw configurations are legal: constant output.

Decomposition:
- cordic_pkg holds:
  - DATA_WIDTH, ANGLE_WIDTH and ITER defaults
  - K_INV_Q15 = 19899
  - state encoding (IDLE=0, RUN=1, DRAIN=2)
  - helper constant PI_OVER_2 = 2^(ANGLE_WIDTH-2)
- Sub-module cordic_valid_delay: an ITER-deep 1-bit shift register with synchronous active-low clear and an "any bit set" output used for the DRAIN exit.

Test Plan:
- Reset, then cfg ftw=0x10000000, phase=0, amp=32767, count=16, start → angles 0x00000000, 0x10000000, …, 0x70000000, 0x80000000 (−2^31), …, 0xF0000000. xin=19898, yin=0. in_valid high 16 cycles. out_valid high 16 cycles starting 16 cycles after the first in_valid. done coincides with the 16th out_valid, and busy drops the next cycle.
- Continuous mode (count=0), ftw=0x40000000, phase=0xC0000000: angle sequence −2^30, 0, 2^30, −2^31, repeating. Assert stop after 10 samples → exactly 10 in_valid and 10 out_valid, then done.
- cfg_valid and start asserted in the same cycle in IDLE → config captured, state stays IDLE, no in_valid. A subsequent lone start runs with the new ftw.
- reset_n low for one cycle at sample 5 of a count=20 burst → all outputs 0 next cycle. No out_valid or done follows for 2·ITER cycles.
- start, stop and cfg_valid pulsed during RUN/DRAIN → ignored, and cfg_ready stays 0. Burst count remains exactly as configured.
- End-to-end with CORDIC instantiated, ftw=2^24, amp=32767 → at each out_valid, Xout/Yout are within ±4 LSB of 32767·cos/sin of the sample angle.

Source files
------------

// File: rtl/cordic_nco_frontend_pkg.sv
// Shared constants and state encoding for the CORDIC NCO front end.
//   DEF_*       default widths/depth, which must match the downstream CORDIC
//   K_INV_Q15   inverse CORDIC gain (~0.607253) in Q15
//   PI_OVER_2   quarter turn at the default angle width
//   state_e     sequencer state encoding
package cordic_nco_frontend_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_ANGLE_WIDTH = 32;
    localparam int unsigned DEF_ITER        = 16;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

    localparam int unsigned K_INV_Q15   = 19899;
    localparam int unsigned K_INV_SHIFT = 15;

    localparam logic [DEF_ANGLE_WIDTH-1:0] PI_OVER_2 =
        DEF_ANGLE_WIDTH'(1) << (DEF_ANGLE_WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/cordic_nco_frontend_if.sv
// Configuration port of the NCO front end (valid/ready write).
//   cfg_valid/cfg_ready  write handshake; ready only while idle
//   cfg_ftw              phase step per sample
//   cfg_phase            start phase
//   cfg_amp              unsigned amplitude
//   cfg_count            samples per burst, 0 = continuous
interface cordic_nco_frontend_if
    import cordic_nco_frontend_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ANGLE_WIDTH = DEF_ANGLE_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) ();

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ANGLE_WIDTH-1:0] cfg_ftw;
    logic [ANGLE_WIDTH-1:0] cfg_phase;
    logic [DATA_WIDTH-2:0]  cfg_amp;
    logic [CNT_WIDTH-1:0]   cfg_count;

    modport master (
        output cfg_valid, cfg_ftw, cfg_phase, cfg_amp, cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ftw, cfg_phase, cfg_amp, cfg_count,
        output cfg_ready
    );

endinterface

// File: rtl/cordic_valid_delay.sv
// Valid delay line mirroring the CORDIC pipeline depth.
//   clock, reset_n  clock and synchronous active-low clear
//   din             valid entering the CORDIC
//   dout            valid leaving the CORDIC (din delayed DEPTH cycles)
//   any_c           some sample is still in flight
//   last_c          exactly one sample remains and it leaves on the next edge
module cordic_valid_delay #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic any_c,
    output logic last_c
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[DEPTH-2:0], din};
        end
    end

    assign dout  = sr_q[DEPTH-1];
    assign any_c = |sr_q;
    // Only the stage feeding the output is occupied; nothing follows it.
    assign last_c = (sr_q[DEPTH-2:0] == {1'b1, {(DEPTH-2){1'b0}}});

endmodule

// File: rtl/cordic_nco_frontend.sv
// Phase-accumulator NCO and burst sequencer feeding a pipelined CORDIC.
//   clock, reset_n   clock and synchronous active-low reset
//   cfg              configuration write port (slave)
//   start, stop      burst start (idle only) / stop request (run only)
//   busy             sequencer not idle
//   angle, xin, yin  CORDIC inputs; xin is gain-precompensated, yin is 0
//   in_valid         angle/xin/yin carry a sample
//   out_valid        CORDIC outputs valid this cycle
//   done             pulse with the final out_valid of a burst
module cordic_nco_frontend
    import cordic_nco_frontend_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ANGLE_WIDTH = DEF_ANGLE_WIDTH,
    parameter int unsigned ITER        = DEF_ITER,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    cordic_nco_frontend_if.slave          cfg,
    input  logic                          start,
    input  logic                          stop,
    output logic                          busy,
    output logic signed [ANGLE_WIDTH-1:0] angle,
    output logic signed [DATA_WIDTH-1:0]  xin,
    output logic signed [DATA_WIDTH-1:0]  yin,
    output logic                          in_valid,
    output logic                          out_valid,
    output logic                          done
);

    localparam int unsigned PROD_WIDTH = DATA_WIDTH - 1 + K_INV_SHIFT;

    state_e                 state_q, state_d;
    logic [ANGLE_WIDTH-1:0] ftw_q, ftw_d;
    logic [ANGLE_WIDTH-1:0] phase_q, phase_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]  xin_q, xin_d;
    logic [ANGLE_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic                   in_valid_q, in_valid_d;
    logic                   done_q, done_d;

    logic [PROD_WIDTH-1:0]  prod_c;
    logic [PROD_WIDTH-1:0]  prod_sh_c;
    logic                   dl_any_c;
    logic                   dl_last_c;

    // Amplitude scaled by 1/K once, at capture time.
    assign prod_c    = PROD_WIDTH'(cfg.cfg_amp) * PROD_WIDTH'(K_INV_Q15);
    assign prod_sh_c = prod_c >> K_INV_SHIFT;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ftw_q      <= '0;
            phase_q    <= '0;
            count_q    <= '0;
            xin_q      <= '0;
            acc_q      <= '0;
            sent_q     <= '0;
            angle_q    <= '0;
            in_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ftw_q      <= ftw_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            xin_q      <= xin_d;
            acc_q      <= acc_d;
            sent_q     <= sent_d;
            angle_q    <= angle_d;
            in_valid_q <= in_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ftw_d      = ftw_q;
        phase_d    = phase_q;
        count_d    = count_q;
        xin_d      = xin_q;
        acc_d      = acc_q;
        sent_d     = sent_q;
        angle_d    = angle_q;
        in_valid_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid) begin
                    // Config wins over a simultaneous start.
                    ftw_d   = cfg.cfg_ftw;
                    phase_d = cfg.cfg_phase;
                    count_d = cfg.cfg_count;
                    xin_d   = DATA_WIDTH'(prod_sh_c);
                end else if (start) begin
                    acc_d   = phase_q;
                    sent_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The sample currently shown is the last when stopping or at terminal count.
                if (stop || ((count_q != '0) && (sent_q == count_q))) begin
                    state_d = ST_DRAIN;
                end else begin
                    angle_d    = acc_q;
                    in_valid_d = 1'b1;
                    acc_d      = acc_q + ftw_q;
                    sent_d     = sent_q + CNT_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                done_d = dl_last_c;
                // An empty line on entry means the burst issued nothing.
                if (done_q || !dl_any_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    cordic_valid_delay #(
        .DEPTH (ITER)
    ) u_valid_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (in_valid_q),
        .dout    (out_valid),
        .any_c   (dl_any_c),
        .last_c  (dl_last_c)
    );

    assign cfg.cfg_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign angle         = angle_q;
    assign xin           = xin_q;
    assign yin           = '0;
    assign in_valid      = in_valid_q;
    assign done          = done_q;

endmodule

// File: tb/tb_cordic_nco_frontend.sv
// Directed, table-driven bench for cordic_nco_frontend.
module tb_cordic_nco_frontend;
    import cordic_nco_frontend_pkg::*;

    localparam int unsigned DW   = DEF_DATA_WIDTH;
    localparam int unsigned AW   = DEF_ANGLE_WIDTH;
    localparam int unsigned ITER = DEF_ITER;
    localparam int unsigned CW   = DEF_CNT_WIDTH;

    typedef struct {
        logic [AW-1:0] ftw;
        logic [AW-1:0] phase;
        logic [DW-2:0] amp;
        logic [CW-1:0] count;
        int            exp_n;
        logic [DW-1:0] exp_xin;
        logic [AW-1:0] exp_last;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          busy;
    logic [AW-1:0] angle;
    logic [DW-1:0] xin;
    logic [DW-1:0] yin;
    logic          in_valid;
    logic          out_valid;
    logic          done;

    int checks   = 0;
    int failures = 0;

    cordic_nco_frontend_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .CNT_WIDTH(CW)) cfg_if ();

    cordic_nco_frontend #(
        .DATA_WIDTH (DW),
        .ANGLE_WIDTH(AW),
        .ITER       (ITER),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cfg      (cfg_if),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .angle    (angle),
        .xin      (xin),
        .yin      (yin),
        .in_valid (in_valid),
        .out_valid(out_valid),
        .done     (done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input vec_t v);
        cfg_if.cfg_ftw   = v.ftw;
        cfg_if.cfg_phase = v.phase;
        cfg_if.cfg_amp   = v.amp;
        cfg_if.cfg_count = v.count;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Start a burst on the current config and follow it until the sequencer is idle.
    task automatic run_burst(input string tag, input vec_t v, input bit noise, input int stop_at);
        int n_iv = 0, n_ov = 0, n_done = 0, ready_bad = 0;
        int first_iv = -1, last_iv = -1, first_ov = -1, last_ov = -1;
        int done_cyc = -1, idle_cyc = -1, cyc = 0;
        int bad_angle = 0, bad_x = 0;
        bit done_ok = 1'b0, finished = 1'b0;
        logic [AW-1:0] exp_a;

        check({tag, "_ready_idle"}, 64'(cfg_if.cfg_ready), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        while (!finished && cyc < 400) begin
            step();
            cyc++;
            if (in_valid) begin
                exp_a = v.phase + AW'(n_iv) * v.ftw;
                if (angle !== exp_a) begin
                    bad_angle++;
                    $display("FAIL %s_angle[%0d] actual=%0h required=%0h", tag, n_iv, angle, exp_a);
                end
                if (xin !== v.exp_xin || yin !== '0) bad_x++;
                if (n_iv == 0) first_iv = cyc;
                last_iv = cyc;
                n_iv++;
            end
            if (out_valid) begin
                if (n_ov == 0) first_ov = cyc;
                last_ov = cyc;
                n_ov++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                done_ok  = out_valid && (n_ov == v.exp_n);
            end
            if (busy) begin
                if (cfg_if.cfg_ready) ready_bad++;
                if (noise) begin
                    start            = (cyc % 3 == 0);
                    cfg_if.cfg_valid = (cyc % 4 == 1);
                    cfg_if.cfg_ftw   = 32'hDEAD_BEEF;
                    cfg_if.cfg_count = 16'd2;
                    stop             = (n_iv >= v.exp_n) && (cyc % 2 == 0);
                end
                if (stop_at != 0 && n_iv == stop_at) stop = 1'b1;
            end else begin
                idle_cyc = cyc;
                finished = 1'b1;
                start            = 1'b0;
                stop             = 1'b0;
                cfg_if.cfg_valid = 1'b0;
            end
        end
        check({tag, "_timeout"}, 64'(finished), 64'd1);
        check({tag, "_angles_bad"}, 64'(bad_angle), 64'd0);
        check({tag, "_xin_yin_bad"}, 64'(bad_x), 64'd0);
        check({tag, "_in_valid_n"}, 64'(n_iv), 64'(v.exp_n));
        check({tag, "_in_valid_contig"}, 64'(last_iv - first_iv), 64'(v.exp_n - 1));
        check({tag, "_out_valid_n"}, 64'(n_ov), 64'(v.exp_n));
        check({tag, "_latency"}, 64'(first_ov - first_iv), 64'(ITER));
        check({tag, "_out_valid_contig"}, 64'(last_ov - first_ov), 64'(v.exp_n - 1));
        check({tag, "_done_n"}, 64'(n_done), 64'd1);
        check({tag, "_done_with_last_ov"}, 64'(done_ok), 64'd1);
        check({tag, "_idle_after_done"}, 64'(idle_cyc - done_cyc), 64'd1);
        check({tag, "_cfg_ready_busy"}, 64'(ready_bad), 64'd0);
        check({tag, "_angle_hold"}, 64'(angle), 64'(v.exp_last));
    endtask

    vec_t tbl [5];
    vec_t v;
    int   n_iv, n_ov, n_done, busy_cnt, guard;

    initial begin
        //        ftw           phase         amp    count exp_n xin    last angle
        tbl[0] = '{32'h1000_0000, 32'h0000_0000, 15'd32767, 16'd16, 16, 16'd19898, 32'hF000_0000};
        tbl[1] = '{32'h0000_0000, 32'h1234_5678, 15'd0,     16'd3,  3,  16'd0,     32'h1234_5678};
        tbl[2] = '{32'h4000_0000, 32'hC000_0000, 15'd16384, 16'd5,  5,  16'd9949,  32'hC000_0000};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 15'd12345, 16'd4,  4,  16'd7496,  32'hFFFF_FFFE};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 15'd1,     16'd1,  1,  16'd0,     32'h8000_0000};

        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ftw = '0;
        cfg_if.cfg_phase = '0;
        cfg_if.cfg_amp = '0;
        cfg_if.cfg_count = '0;
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_ready", 64'(cfg_if.cfg_ready), 64'd1);
        check("rst_angle", 64'(angle), 64'd0);
        check("rst_xin", 64'(xin), 64'd0);
        check("rst_valids_done", {61'd0, in_valid, out_valid, done}, 64'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            do_cfg(tbl[i]);
            run_burst($sformatf("vec%0d", i), tbl[i], (i == 2), 0);
        end

        // Config and start together: config taken, no burst.
        cfg_if.cfg_ftw   = 32'h2000_0000;
        cfg_if.cfg_phase = 32'h0000_0000;
        cfg_if.cfg_amp   = 15'd32767;
        cfg_if.cfg_count = 16'd2;
        cfg_if.cfg_valid = 1'b1;
        start = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b0;
        step();
        check("cfgstart_busy", 64'(busy), 64'd0);
        check("cfgstart_in_valid", 64'(in_valid), 64'd0);
        check("cfgstart_xin", 64'(xin), 64'd19898);
        v = '{32'h2000_0000, 32'h0000_0000, 15'd32767, 16'd2, 2, 16'd19898, 32'h2000_0000};
        run_burst("cfgstart_run", v, 1'b0, 0);

        // Continuous mode stopped after 10 samples.
        v = '{32'h4000_0000, PI_OVER_2 + 32'h8000_0000, 15'd32767, 16'd0, 10, 16'd19898, 32'h0000_0000};
        do_cfg(v);
        run_burst("cont_stop", v, 1'b0, 10);

        // Reset in the middle of a 20-sample burst.
        v = '{32'h0100_0000, 32'h0000_0000, 15'd32767, 16'd20, 20, 16'd19898, 32'h0000_0000};
        do_cfg(v);
        start = 1'b1;
        step();
        start = 1'b0;
        n_iv = 0;
        guard = 0;
        while (n_iv < 6 && guard < 50) begin
            step();
            guard++;
            if (in_valid) n_iv++;
        end
        check("midrst_reach_sample5", 64'(n_iv), 64'd6);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_angle", 64'(angle), 64'd0);
        check("midrst_xin", 64'(xin), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valids_done", {61'd0, in_valid, out_valid, done}, 64'd0);
        n_ov = 0;
        n_done = 0;
        busy_cnt = 0;
        for (int c = 0; c < 2 * int'(ITER) + 4; c++) begin
            step();
            if (out_valid) n_ov++;
            if (done) n_done++;
            if (busy) busy_cnt++;
        end
        check("midrst_no_out_valid", 64'(n_ov), 64'd0);
        check("midrst_no_done", 64'(n_done), 64'd0);
        check("midrst_stays_idle", 64'(busy_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
